// File: rtl/seq_checker_pkg.sv
// Shared types and constants for the seq_checker receive-side stream checker.
package seq_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int              ERR_W   = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/seq_checker.sv
// Checks an incrementing count stream (1, 2, 3, ...) over valid/ready and reports done/pass.
// Optional SEQ_CHECKER_RESYNC_EN: on a mismatch, re-align the expectation to the received value.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | accepting and comparing transfers
// DONE  | NUM_TESTS transfers seen; done/pass held until next start
module seq_checker
    import seq_checker_pkg::*;
#(
    parameter int NUM_TESTS = 100,
    parameter int WIDTH     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_mismatch,
    output logic [ERR_W-1:0] o_err_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass
);

    localparam int               CNT_W     = $clog2(NUM_TESTS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_TESTS - 1);
    localparam logic [WIDTH-1:0] FIRST_VAL = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_expected;
    logic [WIDTH-1:0] w_expected_nxt;
    logic [CNT_W-1:0] r_xfer_cnt;
    logic             r_mismatch;
    logic             w_xfer;
    logic             w_miss;
    logic             w_last;
    logic             w_enter_run;
    logic [ERR_W-1:0] w_err_count;

    assign w_xfer      = i_in_valid && (r_state == RUN);
    assign w_miss      = w_xfer && (i_in_data != r_expected);
    assign w_last      = w_xfer && (r_xfer_cnt == LAST_IDX);
    assign w_enter_run = i_start && (r_state != RUN);

`ifdef SEQ_CHECKER_RESYNC_EN
    // Re-aligning on the received value turns a drop/duplicate into a single error.
    assign w_expected_nxt = w_miss ? (i_in_data + FIRST_VAL) : (r_expected + FIRST_VAL);
`else
    assign w_expected_nxt = r_expected + FIRST_VAL;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_pass      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) w_state_nxt = RUN;
            end
            RUN: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                o_done = 1'b1;
                o_pass = (w_err_count == '0);
                if (i_start) w_state_nxt = RUN;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_expected <= FIRST_VAL;
            r_xfer_cnt <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_mismatch <= w_miss;
            if (w_enter_run) begin
                r_expected <= FIRST_VAL;
                r_xfer_cnt <= '0;
            end else if (w_xfer) begin
                r_expected <= w_expected_nxt;
                r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
            end
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_enter_run),
        .i_inc  (w_miss),
        .o_count(w_err_count)
    );

    assign o_mismatch  = r_mismatch;
    assign o_err_count = w_err_count;

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker: default 8-bit/100-transfer instance plus a 4-bit/20-transfer wrap instance.
module tb_seq_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_in_valid = 1'b0;
    logic [7:0]  i_in_data = '0;
    logic        o_in_ready, o_mismatch, o_busy, o_done, o_pass;
    logic [15:0] o_err_count;

    logic        w4_start = 1'b0;
    logic        w4_valid = 1'b0;
    logic [3:0]  w4_data = '0;
    logic        w4_ready, w4_mismatch, w4_busy, w4_done, w4_pass;
    logic [15:0] w4_err;

    int n_checks = 0;
    int n_pass   = 0;
    int mis_cnt;
    int first_mis;
    logic pre_last_done, pre_last_busy;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    seq_checker #(.NUM_TESTS(100), .WIDTH(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_in_valid(i_in_valid),
        .o_in_ready(o_in_ready), .i_in_data(i_in_data), .o_mismatch(o_mismatch),
        .o_err_count(o_err_count), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass)
    );

    seq_checker #(.NUM_TESTS(20), .WIDTH(4)) dut_w4 (
        .i_clk(clk), .i_rst(rst), .i_start(w4_start), .i_in_valid(w4_valid),
        .o_in_ready(w4_ready), .i_in_data(w4_data), .o_mismatch(w4_mismatch),
        .o_err_count(w4_err), .o_busy(w4_busy), .o_done(w4_done), .o_pass(w4_pass)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic build_clean();
        q.delete();
        for (int v = 1; v <= 100; v++) q.push_back(8'(v));
    endtask

    // Sends q; optional random stalls and start held high throughout.
    task automatic send_q(input bit stalls, input bit hold_start);
        mis_cnt   = 0;
        first_mis = -1;
        i_start   = hold_start;
        for (int i = 0; i < q.size(); i++) begin
            if (stalls) begin
                int s;
                s = $urandom_range(0, 2);
                for (int k = 0; k < s; k++) begin
                    i_in_valid = 1'b0;
                    i_in_data  = 8'($urandom);
                    tick();
                    if (o_mismatch) mis_cnt++;
                end
            end
            pre_last_done = o_done;
            pre_last_busy = o_busy;
            i_in_valid = 1'b1;
            i_in_data  = q[i];
            tick();
            if (o_mismatch) begin
                mis_cnt++;
                if (first_mis < 0) first_mis = i + 1;
            end
        end
        i_in_valid = 1'b0;
        i_start    = 1'b0;
    endtask

    task automatic check_end(input string tag, input int exp_err);
        check({tag, "_busy_before_last"}, 32'(pre_last_busy), 32'd1);
        check({tag, "_done_before_last"}, 32'(pre_last_done), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd1);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_ready"}, 32'(o_in_ready), 32'd0);
        check({tag, "_err"}, 32'(o_err_count), 32'(exp_err));
        check({tag, "_pulses"}, 32'(mis_cnt), 32'(exp_err));
        check({tag, "_pass"}, 32'(o_pass), 32'(exp_err == 0));
    endtask

    initial begin
        #2;
        check("rst_outputs", {27'd0, o_in_ready, o_mismatch, o_busy, o_done, o_pass}, 32'd0);
        check("rst_err", 32'(o_err_count), 32'd0);
        #20;
        rst = 1'b0;
        tick();

        // in_valid in IDLE must not be accepted
        i_in_valid = 1'b1;
        i_in_data  = 8'd1;
        tick();
        tick();
        i_in_valid = 1'b0;
        check("idle_ignored", {28'd0, o_in_ready, o_busy, o_done, o_mismatch}, 32'd0);

        // Clean stream
        start_run();
        check("start_ready", 32'(o_in_ready), 32'd1);
        check("start_busy", 32'(o_busy), 32'd1);
        build_clean();
        send_q(1'b0, 1'b0);
        check_end("clean", 0);
        tick();
        check("done_held", 32'(o_done), 32'd1);

        // Single corruption at item 50
        start_run();
        check("restart_done_clr", 32'(o_done), 32'd0);
        build_clean();
        q[49] = 8'd0;
        send_q(1'b0, 1'b0);
        check("corrupt_first_pulse", 32'(first_mis), 32'd50);
`ifdef SEQ_CHECKER_RESYNC_EN
        check_end("corrupt", 2);
`else
        check_end("corrupt", 1);
`endif

        // Dropped item 5
        start_run();
        check("restart_err_clr", 32'(o_err_count), 32'd0);
        q.delete();
        for (int v = 1; v <= 4; v++) q.push_back(8'(v));
        for (int v = 6; v <= 101; v++) q.push_back(8'(v));
        send_q(1'b0, 1'b0);
        check("drop_first_pulse", 32'(first_mis), 32'd5);
`ifdef SEQ_CHECKER_RESYNC_EN
        check_end("drop", 1);
`else
        check_end("drop", 96);
`endif

        // Stalls with start held high during RUN
        start_run();
        build_clean();
        send_q(1'b1, 1'b1);
        check_end("stall", 0);

        // Reset mid-run after the 30th transfer (30th corrupted so err/mismatch are set)
        start_run();
        q.delete();
        for (int v = 1; v <= 29; v++) q.push_back(8'(v));
        q.push_back(8'd77);
        send_q(1'b0, 1'b0);
        check("prerst_mismatch", 32'(o_mismatch), 32'd1);
        check("prerst_err", 32'(o_err_count), 32'd1);
        rst = 1'b1;
        #2;
        check("midrst_outputs", {27'd0, o_in_ready, o_mismatch, o_busy, o_done, o_pass}, 32'd0);
        check("midrst_err", 32'(o_err_count), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("postrst_idle", {30'd0, o_busy, o_in_ready}, 32'd0);
        start_run();
        build_clean();
        send_q(1'b0, 1'b0);
        check_end("postrst", 0);

        // Wrap-around on the 4-bit instance: 1..15, 0, 1..4
        w4_start = 1'b1;
        tick();
        w4_start = 1'b0;
        mis_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            w4_valid = 1'b1;
            w4_data  = (i < 15) ? 4'(i + 1) : 4'(i - 15);
            tick();
            if (w4_mismatch) mis_cnt++;
        end
        w4_valid = 1'b0;
        check("wrap_pulses", 32'(mis_cnt), 32'd0);
        check("wrap_err", 32'(w4_err), 32'd0);
        check("wrap_done", 32'(w4_done), 32'd1);
        check("wrap_pass", 32'(w4_pass), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
